// File: rtl/music_pkg.sv
// Shared widths, FSM state codes and song table for the song reader.
// song_word() holds the song data that song_rom registers.
package music_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int WORD_W = NOTE_W + DUR_W;

    localparam logic [DUR_W-1:0] END_DUR = '0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_PAUSE    = 3'd4;
    localparam logic [2:0] S_FINISHED = 3'd5;

    // Word layout is {note, dur}; dur == END_DUR marks end of song.
    function automatic logic [WORD_W-1:0] song_word(
        input logic [ADDR_W-1:0] addr
    );
        logic [SONG_W-1:0] s;
        logic [IDX_W-1:0]  i;
        logic [NOTE_W-1:0] n;
        logic [DUR_W-1:0]  d;
        s = addr[ADDR_W-1:IDX_W];
        i = addr[IDX_W-1:0];
        n = '0;
        d = '0;
        case (s)
            2'd0: begin
                if (i == 5'd0) begin
                    n = 6'd12;
                    d = 6'd4;
                end else if (i == 5'd1) begin
                    n = 6'd20;
                    d = 6'd8;
                end
            end
            // Full 32-entry song with no end marker.
            2'd1: begin
                n = NOTE_W'(i) + 6'd1;
                d = 6'd32 - DUR_W'(i);
            end
            2'd2: begin
                if (i < 5'd10) begin
                    n = 6'd40 + NOTE_W'(i);
                    d = DUR_W'(i) + 6'd2;
                end
            end
            default: begin
                if (i < 5'd7) begin
                    n = (NOTE_W'(i) << 1) + 6'd1;
                    d = 6'd5;
                end
            end
        endcase
        return {n, d};
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Handshake bundle between the music controller/note_player and song_reader.
// master drives play/song/note_done; slave (song_reader) drives the note pair.
interface song_reader_if;
    import music_pkg::*;

    logic              play;
    logic [SONG_W-1:0] song;
    logic              note_done;
    logic [NOTE_W-1:0] note_to_load;
    logic [DUR_W-1:0]  duration_to_load;
    logic              load_new_note;
    logic              song_done;

    modport master (
        output play, song, note_done,
        input  note_to_load, duration_to_load, load_new_note, song_done
    );

    modport slave (
        input  play, song, note_done,
        output note_to_load, duration_to_load, load_new_note, song_done
    );

endinterface

// File: rtl/song_rom.sv
// Song storage: addr = {song, idx}, dout = {note, dur}, one-cycle registered read.
// Ports: clk, addr [ADDR_W-1:0], dout [WORD_W-1:0].
module song_rom
    import music_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        r_dout <= song_word(addr);
    end

    assign dout = r_dout;

endmodule

// File: rtl/song_reader.sv
// Walks a song in song_rom, handing one (note, duration) pair per note_done.
// Ports: clk, reset (sync, active-high), bus (song_reader_if.slave).
module song_reader
    import music_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.slave  bus
);

    logic [2:0]        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [SONG_W-1:0] r_song_q;
    logic [NOTE_W-1:0] r_note;
    logic [DUR_W-1:0]  r_dur;
    logic              r_load;
    logic              r_done;

    logic [WORD_W-1:0] w_word;
    logic [NOTE_W-1:0] w_note;
    logic [DUR_W-1:0]  w_dur;
    logic              w_last;
    logic              w_song_chg;

    song_rom u_rom (
        .clk  (clk),
        .addr ({r_song_q, r_idx}),
        .dout (w_word)
    );

    assign w_note = w_word[WORD_W-1:DUR_W];
    assign w_dur  = w_word[DUR_W-1:0];
    assign w_last = (r_idx == '1);

    // A new song select restarts from any active state; IDLE latches on play.
    assign w_song_chg = (r_state != S_IDLE) && (bus.song != r_song_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_song_q <= '0;
            r_note   <= '0;
            r_dur    <= '0;
            r_load   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            if (w_song_chg) begin
                r_song_q <= bus.song;
                r_idx    <= '0;
                r_state  <= bus.play ? S_FETCH : S_PAUSE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.play) begin
                            r_song_q <= bus.song;
                            r_idx    <= '0;
                            r_state  <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        r_state <= bus.play ? S_CHECK : S_PAUSE;
                    end
                    S_CHECK: begin
                        if (!bus.play) begin
                            r_state <= S_PAUSE;
                        end else if (w_dur == END_DUR) begin
                            r_state <= S_FINISHED;
                            r_done  <= 1'b1;
                        end else begin
                            r_note  <= w_note;
                            r_dur   <= w_dur;
                            r_load  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // Pause wins over note_done so the note replays in full.
                        if (!bus.play) begin
                            r_state <= S_PAUSE;
                        end else if (bus.note_done) begin
                            if (w_last) begin
                                r_state <= S_FINISHED;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx   <= r_idx + IDX_W'(1);
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (bus.play) begin
                            r_state <= S_FETCH;
                        end
                    end
                    S_FINISHED: begin
                        if (!bus.play) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.note_to_load     = r_note;
    assign bus.duration_to_load = r_dur;
    assign bus.load_new_note    = r_load;
    assign bus.song_done        = r_done;

endmodule
